// File: rtl/diff_link_pkg.sv
// Shared definitions for the differential link: code layout, frame type and checksum.
package diff_link_pkg;
  localparam int CODE_W  = 26;
  localparam int SYNC_HI = 25;
  localparam int SYNC_LO = 24;
  localparam int TYPE_HI = 23;
  localparam int TYPE_LO = 20;
  localparam int PAY_HI  = 19;
  localparam int PAY_LO  = 4;
  localparam int SUM_HI  = 3;
  localparam int SUM_LO  = 0;

  localparam logic [1:0] SYNC_WORD = 2'b10;

  typedef struct packed {
    logic [3:0]  ftype;
    logic [15:0] payload;
  } frame_t;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_CONFIRMING = 2'd1,
    ST_LOCKED     = 2'd2
  } rx_state_t;

  // The checksum covers the type nibble and the four payload nibbles.
  function automatic logic [3:0] code_checksum(input logic [CODE_W-1:0] code);
    code_checksum = code[TYPE_HI:TYPE_LO] ^ code[PAY_HI:PAY_HI-3] ^ code[PAY_HI-4:PAY_HI-7]
                  ^ code[PAY_LO+7:PAY_LO+4] ^ code[PAY_LO+3:PAY_LO];
  endfunction
endpackage

// File: rtl/frame_fifo.sv
// First-word fall-through FIFO of frames; a push into a full FIFO is taken only alongside a pop.
module frame_fifo
  import diff_link_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic   clk_in,
  input  logic   rst_in,
  input  logic   push,
  input  logic   pop,
  input  frame_t wr_data,
  output frame_t head,
  output logic   full,
  output logic   empty
);
  localparam int AW = $clog2(DEPTH);

  frame_t      mem_r [DEPTH];
  logic [AW:0] wr_ptr_r;
  logic [AW:0] rd_ptr_r;
  logic        full_s;
  logic        empty_s;
  logic        do_push_s;
  logic        do_pop_s;

  assign empty_s   = (wr_ptr_r == rd_ptr_r);
  assign full_s    = (wr_ptr_r[AW] != rd_ptr_r[AW]) && (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
  assign do_pop_s  = pop && !empty_s;
  assign do_push_s = push && (!full_s || do_pop_s);

  assign head  = mem_r[rd_ptr_r[AW-1:0]];
  assign full  = full_s;
  assign empty = empty_s;

  // Storage and pointer update
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= '0;
      end
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
    end else begin
      if (do_push_s) begin
        mem_r[wr_ptr_r[AW-1:0]] <= wr_data;
        wr_ptr_r <= wr_ptr_r + (AW+1)'(1);
      end else begin
        wr_ptr_r <= wr_ptr_r;
      end
      if (do_pop_s) begin
        rd_ptr_r <= rd_ptr_r + (AW+1)'(1);
      end else begin
        rd_ptr_r <= rd_ptr_r;
      end
    end
  end
endmodule

// File: rtl/diff_rx_frame.sv
// Frame qualifier behind diff_rx: checks sync/checksum, confirms repeated codes,
// suppresses retransmissions and queues accepted frames for a valid/ready consumer.
module diff_rx_frame
  import diff_link_pkg::*;
#(
  parameter int CONFIRM = 2,
  parameter int TIMEOUT = 100000,
  parameter int DEPTH   = 4
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic [CODE_W-1:0] code_in,
  input  logic              new_code_in,
  output logic [3:0]        type_out,
  output logic [15:0]       payload_out,
  output logic              valid_out,
  input  logic              ready_in,
  output logic [7:0]        err_sync_out,
  output logic [7:0]        err_sum_out,
  output logic [7:0]        drop_out
);
  localparam int              TW      = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0]   TMO_MAX = TW'(TIMEOUT);
  localparam logic [3:0]      CONF_N  = 4'(CONFIRM);

  rx_state_t     state_r;
  rx_state_t     eff_state_s;
  rx_state_t     next_state_s;
  frame_t        cand_r;
  frame_t        next_cand_s;
  frame_t        frame_s;
  frame_t        head_s;
  logic [3:0]    cnt_r;
  logic [3:0]    next_cnt_s;
  logic [TW-1:0] tmo_r;
  logic [7:0]    err_sync_r;
  logic [7:0]    err_sum_r;
  logic [7:0]    drop_r;
  logic          tmo_hit_s;
  logic          sync_ok_s;
  logic          sum_ok_s;
  logic          accept_s;
  logic          bad_sync_s;
  logic          bad_sum_s;
  logic          full_s;
  logic          empty_s;
  logic          pop_s;

  assign frame_s   = frame_t'(code_in[TYPE_HI:PAY_LO]);
  assign sync_ok_s = (code_in[SYNC_HI:SYNC_LO] == SYNC_WORD);
  assign sum_ok_s  = (code_in[SUM_HI:SUM_LO] == code_checksum(code_in));
  assign pop_s     = !empty_s && ready_in;

  // Qualification and confirmation decisions for the current strobe
  always_comb begin
    tmo_hit_s    = (tmo_r == TMO_MAX);
    // A saturated timeout makes this cycle's strobe start from a clean slate.
    eff_state_s  = tmo_hit_s ? ST_IDLE : state_r;
    next_state_s = eff_state_s;
    next_cand_s  = cand_r;
    next_cnt_s   = cnt_r;
    accept_s     = 1'b0;
    bad_sync_s   = 1'b0;
    bad_sum_s    = 1'b0;
    if (new_code_in) begin
      if (!sync_ok_s) begin
        bad_sync_s   = 1'b1;
        next_state_s = ST_IDLE;
      end else if (!sum_ok_s) begin
        bad_sum_s    = 1'b1;
        next_state_s = ST_IDLE;
      end else if ((eff_state_s == ST_CONFIRMING) && (frame_s == cand_r)) begin
        next_cnt_s = cnt_r + 4'd1;
        if ((cnt_r + 4'd1) >= CONF_N) begin
          accept_s     = 1'b1;
          next_state_s = ST_LOCKED;
        end else begin
          next_state_s = ST_CONFIRMING;
        end
      end else if ((eff_state_s == ST_LOCKED) && (frame_s == cand_r)) begin
        next_state_s = ST_LOCKED;
      end else begin
        next_cand_s = frame_s;
        next_cnt_s  = 4'd1;
        if (CONF_N == 4'd1) begin
          accept_s     = 1'b1;
          next_state_s = ST_LOCKED;
        end else begin
          next_state_s = ST_CONFIRMING;
        end
      end
    end else begin
      next_state_s = eff_state_s;
    end
  end

  // FSM, timeout and saturating error/drop counters
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_r    <= ST_IDLE;
      cand_r     <= '0;
      cnt_r      <= 4'd0;
      tmo_r      <= '0;
      err_sync_r <= 8'd0;
      err_sum_r  <= 8'd0;
      drop_r     <= 8'd0;
    end else begin
      state_r <= next_state_s;
      cand_r  <= next_cand_s;
      cnt_r   <= next_cnt_s;
      if (new_code_in) begin
        tmo_r <= '0;
      end else if (!tmo_hit_s) begin
        tmo_r <= tmo_r + TW'(1);
      end else begin
        tmo_r <= tmo_r;
      end
      if (bad_sync_s && (err_sync_r != 8'hFF)) begin
        err_sync_r <= err_sync_r + 8'd1;
      end else begin
        err_sync_r <= err_sync_r;
      end
      if (bad_sum_s && (err_sum_r != 8'hFF)) begin
        err_sum_r <= err_sum_r + 8'd1;
      end else begin
        err_sum_r <= err_sum_r;
      end
      if (accept_s && full_s && !pop_s && (drop_r != 8'hFF)) begin
        drop_r <= drop_r + 8'd1;
      end else begin
        drop_r <= drop_r;
      end
    end
  end

  frame_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk_in  (clk_in),
    .rst_in  (rst_in),
    .push    (accept_s),
    .pop     (pop_s),
    .wr_data (frame_s),
    .head    (head_s),
    .full    (full_s),
    .empty   (empty_s)
  );

  assign valid_out    = !empty_s;
  assign type_out     = head_s.ftype;
  assign payload_out  = head_s.payload;
  assign err_sync_out = err_sync_r;
  assign err_sum_out  = err_sum_r;
  assign drop_out     = drop_r;
endmodule

// File: tb/tb_diff_rx_frame.sv
// Directed bench for diff_rx_frame: a vector table plus hand-written multi-cycle sequences.
module tb_diff_rx_frame;
  localparam int TMO = 20;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [25:0] code = 26'd0;
  logic        new_code = 1'b0;
  logic        ready = 1'b0;
  logic [3:0]  type_o;
  logic [15:0] payload_o;
  logic        valid_o;
  logic [7:0]  err_sync_o;
  logic [7:0]  err_sum_o;
  logic [7:0]  drop_o;

  int n_chk = 0;
  int n_fail = 0;

  diff_rx_frame #(.CONFIRM(2), .TIMEOUT(TMO), .DEPTH(4)) dut (
    .clk_in       (clk),
    .rst_in       (rst_n),
    .code_in      (code),
    .new_code_in  (new_code),
    .type_out     (type_o),
    .payload_out  (payload_o),
    .valid_out    (valid_o),
    .ready_in     (ready),
    .err_sync_out (err_sync_o),
    .err_sum_out  (err_sum_o),
    .drop_out     (drop_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        nc;
    logic [25:0] cd;
    logic        rdy;
    logic        ev;
    logic [3:0]  et;
    logic [15:0] ep;
    logic [7:0]  es;
    logic [7:0]  esum;
    logic [7:0]  ed;
  } vec_t;

  vec_t tbl [12];

  function automatic logic [25:0] mk(input logic [3:0] t, input logic [15:0] p);
    mk = {2'b10, t, p, t ^ p[15:12] ^ p[11:8] ^ p[7:4] ^ p[3:0]};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step(input logic nc, input logic [25:0] cd, input logic rdy);
    new_code = nc;
    code     = cd;
    ready    = rdy;
    @(posedge clk);
    #1;
    new_code = 1'b0;
  endtask

  logic [25:0] c_code;
  logic [25:0] bad_sync;
  logic [25:0] bad_sum;
  logic [25:0] d_code;
  int          seen;

  initial begin
    c_code   = 26'b10_0011_1010_0101_1100_0011_0011;
    bad_sync = {2'b01, 4'h3, 16'hA5C3, 4'h3};
    bad_sum  = {2'b10, 4'h3, 16'hA5C3, 4'h2};
    d_code   = mk(4'h5, 16'h1234);

    tbl[0]  = '{1'b0, 26'd0,    1'b0, 1'b0, 4'h0, 16'h0,    8'd0, 8'd0, 8'd0};
    tbl[1]  = '{1'b1, c_code,   1'b0, 1'b0, 4'h0, 16'h0,    8'd0, 8'd0, 8'd0};
    tbl[2]  = '{1'b1, c_code,   1'b0, 1'b1, 4'h3, 16'hA5C3, 8'd0, 8'd0, 8'd0};
    tbl[3]  = '{1'b1, c_code,   1'b0, 1'b1, 4'h3, 16'hA5C3, 8'd0, 8'd0, 8'd0};
    tbl[4]  = '{1'b0, 26'd0,    1'b1, 1'b0, 4'h0, 16'h0,    8'd0, 8'd0, 8'd0};
    tbl[5]  = '{1'b1, c_code,   1'b1, 1'b0, 4'h0, 16'h0,    8'd0, 8'd0, 8'd0};
    tbl[6]  = '{1'b1, bad_sync, 1'b0, 1'b0, 4'h0, 16'h0,    8'd1, 8'd0, 8'd0};
    tbl[7]  = '{1'b1, c_code,   1'b0, 1'b0, 4'h0, 16'h0,    8'd1, 8'd0, 8'd0};
    tbl[8]  = '{1'b1, bad_sum,  1'b0, 1'b0, 4'h0, 16'h0,    8'd1, 8'd1, 8'd0};
    tbl[9]  = '{1'b1, c_code,   1'b0, 1'b0, 4'h0, 16'h0,    8'd1, 8'd1, 8'd0};
    tbl[10] = '{1'b1, c_code,   1'b0, 1'b1, 4'h3, 16'hA5C3, 8'd1, 8'd1, 8'd0};
    tbl[11] = '{1'b0, 26'd0,    1'b1, 1'b0, 4'h0, 16'h0,    8'd1, 8'd1, 8'd0};

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst valid", 32'(valid_o), 32'd0);
    chk("rst type", 32'(type_o), 32'd0);
    chk("rst payload", 32'(payload_o), 32'd0);
    chk("rst err_sync", 32'(err_sync_o), 32'd0);
    chk("rst err_sum", 32'(err_sum_o), 32'd0);
    chk("rst drop", 32'(drop_o), 32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 12; i++) begin
      step(tbl[i].nc, tbl[i].cd, tbl[i].rdy);
      chk($sformatf("vec%0d valid", i), 32'(valid_o), 32'(tbl[i].ev));
      chk($sformatf("vec%0d err_sync", i), 32'(err_sync_o), 32'(tbl[i].es));
      chk($sformatf("vec%0d err_sum", i), 32'(err_sum_o), 32'(tbl[i].esum));
      chk($sformatf("vec%0d drop", i), 32'(drop_o), 32'(tbl[i].ed));
      if (tbl[i].ev) begin
        chk($sformatf("vec%0d type", i), 32'(type_o), 32'(tbl[i].et));
        chk($sformatf("vec%0d payload", i), 32'(payload_o), 32'(tbl[i].ep));
      end
    end

    // Timeout: one cycle short keeps suppression, a full TIMEOUT re-arms acceptance
    step(1'b1, c_code, 1'b0);
    chk("tmo dup0 valid", 32'(valid_o), 32'd0);
    repeat (TMO - 1) step(1'b0, c_code, 1'b0);
    step(1'b1, c_code, 1'b0);
    chk("tmo short valid", 32'(valid_o), 32'd0);
    repeat (TMO) step(1'b0, c_code, 1'b0);
    step(1'b1, c_code, 1'b0);
    chk("tmo first valid", 32'(valid_o), 32'd0);
    step(1'b1, c_code, 1'b0);
    chk("tmo second valid", 32'(valid_o), 32'd1);
    chk("tmo type", 32'(type_o), 32'h3);
    chk("tmo payload", 32'(payload_o), 32'hA5C3);
    step(1'b0, c_code, 1'b1);
    chk("tmo popped", 32'(valid_o), 32'd0);

    // Five repeats with the consumer ready deliver exactly one frame
    seen = 0;
    for (int i = 0; i < 7; i++) begin
      step((i < 5) ? 1'b1 : 1'b0, d_code, 1'b1);
      if (valid_o) begin
        seen++;
        chk("rep5 payload", 32'(payload_o), 32'h1234);
      end
    end
    chk("rep5 frames", 32'(seen), 32'd1);
    ready = 1'b0;

    // Overflow: six frames into four entries
    for (int k = 0; k < 6; k++) begin
      step(1'b1, mk(4'(8 + k), 16'(16'hB000 + k)), 1'b0);
      step(1'b1, mk(4'(8 + k), 16'(16'hB000 + k)), 1'b0);
    end
    chk("ovf drop", 32'(drop_o), 32'd2);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("ovf%0d valid", k), 32'(valid_o), 32'd1);
      chk($sformatf("ovf%0d type", k), 32'(type_o), 32'(8 + k));
      chk($sformatf("ovf%0d payload", k), 32'(payload_o), 32'(16'hB000 + k));
      step(1'b0, 26'd0, 1'b1);
    end
    chk("ovf empty", 32'(valid_o), 32'd0);
    ready = 1'b0;

    // Asynchronous reset mid-confirmation with two frames queued
    step(1'b1, mk(4'h1, 16'h1111), 1'b0);
    step(1'b1, mk(4'h1, 16'h1111), 1'b0);
    step(1'b1, mk(4'h2, 16'h2222), 1'b0);
    step(1'b1, mk(4'h2, 16'h2222), 1'b0);
    step(1'b1, c_code, 1'b0);
    chk("pre-rst valid", 32'(valid_o), 32'd1);
    chk("pre-rst type", 32'(type_o), 32'h1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst valid", 32'(valid_o), 32'd0);
    chk("arst type", 32'(type_o), 32'd0);
    chk("arst payload", 32'(payload_o), 32'd0);
    chk("arst err_sync", 32'(err_sync_o), 32'd0);
    chk("arst err_sum", 32'(err_sum_o), 32'd0);
    chk("arst drop", 32'(drop_o), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    step(1'b1, c_code, 1'b0);
    chk("post-rst first valid", 32'(valid_o), 32'd0);
    step(1'b1, c_code, 1'b0);
    chk("post-rst second valid", 32'(valid_o), 32'd1);
    chk("post-rst type", 32'(type_o), 32'h3);
    chk("post-rst payload", 32'(payload_o), 32'hA5C3);

    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_fail);
    $finish;
  end
endmodule
